// File: rtl/rv_core_pkg.sv
// Shared core types: instruction word width, the canonical NOP, and the
// fetch-queue entry that pairs a fetched instruction with its PC.
package rv_core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular sync FIFO of fetch entries with flush. Pointers wrap mod DEPTH,
// count runs 0..DEPTH. A push into a full queue is accepted only alongside a pop.
module fetch_queue
  import rv_core_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  fetch_entry_t       push_entry,
  output fetch_entry_t       head_entry,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[tail_q] = push_entry;
        tail_d        = PTR_W'(tail_q + 1'b1);
      end
      if (pop_ok) begin
        head_d = PTR_W'(head_q + 1'b1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_entry = mem_q[head_q];
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational inst_mem, queues
// {pc, instr} pairs for decode, handles redirects and halts on out-of-range PCs.
module instr_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DEPTH      = 2,
  parameter int          IMEM_WORDS = 1001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  // Handshake: a word moves to decode on a cycle where dec_valid and dec_ready
  // are both high; dec_valid never depends on dec_ready, and dec_* hold stable
  // while dec_valid is high and dec_ready is low.

  localparam int          CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  logic [31:0]      pc_q, pc_d;
  logic             fault_q, fault_d;
  logic [31:0]      fcount_q, fcount_d;
  logic             oob, pop, push, q_full;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     head, new_entry;

  assign oob       = (pc_q >= PC_LIMIT);
  assign q_full    = (q_count == CNT_W'(DEPTH));
  assign dec_valid = (q_count != '0);
  assign pop       = dec_valid & dec_ready;
  assign push      = fetch_en & ~redirect & ~fault_q & ~oob & (~q_full | pop);
  assign new_entry = '{pc: pc_q, instr: imem_instr};

  always_comb begin
    pc_d     = pc_q;
    fault_d  = fault_q;
    fcount_d = fcount_q;
    if (redirect) begin
      pc_d    = redirect_pc & ~32'd3;
      fault_d = 1'b0;
    end else begin
      if (oob) fault_d = 1'b1;
      if (push) begin
        pc_d     = pc_q + 32'd4;
        fcount_d = fcount_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      fault_q  <= 1'b0;
      fcount_q <= '0;
    end else begin
      pc_q     <= pc_d;
      fault_q  <= fault_d;
      fcount_q <= fcount_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect),
    .push       (push),
    .pop        (pop),
    .push_entry (new_entry),
    .head_entry (head),
    .count      (q_count)
  );

  assign imem_pc     = pc_q;
  assign dec_instr   = dec_valid ? head.instr : NOP_INSTR;
  assign dec_pc      = dec_valid ? head.pc : 32'd0;
  assign fetch_fault = fault_q;
  assign fetch_count = fcount_q;

endmodule
